// File: rtl/mem_access_unit_if.sv
// Request/response and memory-port bundle for mem_access_unit.
// slave: the load/store unit; master: the requester plus memory side.
interface mem_access_unit_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 16
);
  localparam int L = WIDTH / 8;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic                  req_byte;
  logic                  req_indirect;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [WIDTH-1:0]      req_wdata;
  logic                  resp_valid;
  logic [WIDTH-1:0]      resp_rdata;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_read;
  logic                  mem_write;
  logic [L-1:0]          mem_byte_enable;
  logic [WIDTH-1:0]      mem_wdata;
  logic [WIDTH-1:0]      mem_rdata;
  logic                  mem_resp;

  modport slave (
    input  req_valid, req_write, req_byte, req_indirect, req_addr, req_wdata,
           mem_rdata, mem_resp,
    output req_ready, resp_valid, resp_rdata, mem_address, mem_read,
           mem_write, mem_byte_enable, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_byte, req_indirect, req_addr, req_wdata,
           mem_rdata, mem_resp,
    input  req_ready, resp_valid, resp_rdata, mem_address, mem_read,
           mem_write, mem_byte_enable, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Multicycle load/store unit: owns MAR/MDR and the memory handshake.
// Optional indirect (pointer-chasing) access: define MEM_ACCESS_INDIRECT_EN.
module mem_access_unit #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 16
) (
  input logic             clk,
  input logic             reset,
  mem_access_unit_if.slave bus
);
  localparam int L  = WIDTH / 8;
  localparam int LB = $clog2(L);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(L - 1);
  localparam logic [L-1:0]          LANE0      = L'(1);

`ifdef MEM_ACCESS_INDIRECT_EN
  typedef enum logic [2:0] {IDLE, IND_RD, READ, WRITE, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, READ, WRITE, DONE} state_t;
`endif

  state_t                r_state;
  state_t                w_next;
  logic                  r_write;
  logic                  r_byte;
  logic [LB-1:0]         r_lane;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WIDTH-1:0]      r_wdata;
  logic [WIDTH-1:0]      r_rdata;
  logic                  w_req_ready;
  logic                  w_resp_valid;
  logic                  w_mem_read;
  logic                  w_mem_write;
  logic [L-1:0]          w_be;
  logic                  w_accept;
  logic                  w_ind;

`ifdef MEM_ACCESS_INDIRECT_EN
  logic                  r_ptr_done;
  logic [ADDR_WIDTH-1:0] w_ptr;
  assign w_ind = bus.req_indirect;
  assign w_ptr = ADDR_WIDTH'(bus.mem_rdata);
`else
  logic w_unused_indirect;
  assign w_ind             = 1'b0;
  assign w_unused_indirect = bus.req_indirect;
`endif

  assign w_accept = bus.req_valid && (r_state == IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode and per-state handshake outputs.
  always_comb begin
    w_next       = r_state;
    w_req_ready  = 1'b0;
    w_resp_valid = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_be         = '0;
    case (r_state)
      IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) begin
          w_next = bus.req_write ? WRITE : READ;
`ifdef MEM_ACCESS_INDIRECT_EN
          if (bus.req_indirect) w_next = IND_RD;
`endif
        end
      end
`ifdef MEM_ACCESS_INDIRECT_EN
      // Pointer fetch, then one strobe-free cycle so the data phase starts
      // as a separate strobe with the pointer already in MAR.
      IND_RD: begin
        w_mem_read = !r_ptr_done;
        if (r_ptr_done) w_next = r_write ? WRITE : READ;
      end
`endif
      READ: begin
        w_mem_read = 1'b1;
        if (bus.mem_resp) w_next = DONE;
      end
      WRITE: begin
        w_mem_write = 1'b1;
        w_be        = r_byte ? (LANE0 << r_lane) : '1;
        if (bus.mem_resp) w_next = DONE;
      end
      DONE: begin
        w_resp_valid = 1'b1;
        w_next       = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // MAR/MDR, request attributes and load result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_write <= 1'b0;
      r_byte  <= 1'b0;
      r_lane  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
`ifdef MEM_ACCESS_INDIRECT_EN
      r_ptr_done <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_write <= bus.req_write;
        r_byte  <= bus.req_byte;
        r_lane  <= bus.req_addr[LB-1:0];
        r_addr  <= (bus.req_byte && !w_ind) ? bus.req_addr
                                            : (bus.req_addr & ALIGN_MASK);
        r_wdata <= bus.req_byte ? {L{bus.req_wdata[7:0]}} : bus.req_wdata;
`ifdef MEM_ACCESS_INDIRECT_EN
        r_ptr_done <= 1'b0;
`endif
      end
`ifdef MEM_ACCESS_INDIRECT_EN
      if (r_state == IND_RD && !r_ptr_done && bus.mem_resp) begin
        r_ptr_done <= 1'b1;
        r_lane     <= w_ptr[LB-1:0];
        r_addr     <= r_byte ? w_ptr : (w_ptr & ALIGN_MASK);
      end
`endif
      if (r_state == READ && bus.mem_resp) begin
        r_rdata <= r_byte ? WIDTH'(bus.mem_rdata[8*r_lane +: 8]) : bus.mem_rdata;
      end
    end
  end

  assign bus.req_ready       = w_req_ready;
  assign bus.resp_valid      = w_resp_valid;
  assign bus.resp_rdata      = r_rdata;
  assign bus.mem_address     = r_addr;
  assign bus.mem_read        = w_mem_read;
  assign bus.mem_write       = w_mem_write;
  assign bus.mem_byte_enable = w_be;
  assign bus.mem_wdata       = r_wdata;
endmodule
